power_to_db_mc: RTL

//  Multi-channel, pipelined power-to-dB converter with valid/ready flow control.

---
 rtl/power_to_db_mc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/power_to_db_mc.sv
// Multi-channel pipelined power-to-dB converter: dB = 10*log10(x) - offset[ch], saturated.
// Define POWER_TO_DB_PEAK_HOLD_EN to add per-channel peak hold with a registered read port.
module power_to_db_mc #(
  parameter int IN_W      = 32,
  parameter int NUM_CH    = 4,
  parameter int FRAC_BITS = 8,
  parameter int DB_W      = 16,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [CH_W-1:0]        ch_i,
  input  logic [IN_W-1:0]        power_i,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic signed [DB_W-1:0] cfg_offset,
`ifdef POWER_TO_DB_PEAK_HOLD_EN
  input  logic                   peak_clr_i,
  input  logic [CH_W-1:0]        peak_ch_i,
  output logic signed [DB_W-1:0] peak_o,
`endif
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CH_W-1:0]        ch_o,
  output logic signed [DB_W-1:0] dB_o,
  output logic                   zero_o,
  output logic                   sat_o
);
  localparam int STAGES = 3;
  localparam int LM_W   = $clog2(IN_W);
  localparam int L_W    = LM_W + FRAC_BITS;
  localparam int P_W    = L_W + 18;
  localparam int Q_W    = P_W - 15;
  localparam int R_W    = ((Q_W > DB_W) ? Q_W : DB_W) + 2;
  localparam logic [P_W:0] K    = (P_W+1)'(197283);
  localparam logic [P_W:0] HALF = (P_W+1)'(32768);
  localparam logic signed [R_W-1:0] R_MAX = R_W'((2**(DB_W-1)) - 1);
  localparam logic signed [R_W-1:0] R_MIN = -R_MAX - R_W'(1);
  localparam logic signed [DB_W-1:0] DB_MAX = R_MAX[DB_W-1:0];
  localparam logic signed [DB_W-1:0] DB_MIN = R_MIN[DB_W-1:0];

  logic              adv, in_vld, ch_ok, cfg_ok, s2_ch_ok;
  logic [STAGES:1]   vld_pipe;
  logic [LM_W-1:0]   msb;
  logic [IN_W+FRAC_BITS-1:0] num, frac_full;
  logic [L_W-1:0]    log2_q;
  logic [P_W:0]      prod;

  logic [CH_W-1:0]   s1_ch, s2_ch;
  logic              s1_zero, s2_zero;
  logic [L_W-1:0]    s1_log2;
  logic [Q_W-1:0]    s2_db;

  logic signed [DB_W-1:0] offset [NUM_CH];
  logic signed [DB_W-1:0] off_sel;
  logic signed [R_W-1:0]  r;

  assign adv     = ready_i || !valid_o;
  assign ready_o = adv && !rst;
  assign valid_o = vld_pipe[STAGES];
  assign ch_ok   = {1'b0, ch_i}   < (CH_W+1)'(NUM_CH);
  assign cfg_ok  = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
  assign s2_ch_ok = {1'b0, s2_ch} < (CH_W+1)'(NUM_CH);
  assign in_vld  = valid_i && ready_o && ch_ok;

  // S1: leading-one detect; x - 2^m is x with its msb cleared
  always_comb begin
    msb = '0;
    for (int i = 0; i < IN_W; i++)
      if (power_i[i]) msb = LM_W'(i);
  end
  assign num       = {power_i ^ (IN_W'(1) << msb), FRAC_BITS'(0)};
  assign frac_full = num >> msb;
  assign log2_q    = {msb, frac_full[FRAC_BITS-1:0]};

  // S2: scale log2 to dB by round(10*log10(2)*2^16), rounded back out of Q16
  assign prod = ((P_W+1)'(s1_log2) * K) + HALF;

  // S3: offset subtract at full width ahead of the clamp
  assign off_sel = s2_ch_ok ? offset[s2_ch] : '0;
  assign r = $signed({{(R_W-Q_W){1'b0}}, s2_db}) - R_W'(off_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_ch    <= '0;
      s1_zero  <= 1'b0;
      s1_log2  <= '0;
      s2_ch    <= '0;
      s2_zero  <= 1'b0;
      s2_db    <= '0;
      ch_o     <= '0;
      dB_o     <= '0;
      zero_o   <= 1'b0;
      sat_o    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
      s1_ch    <= ch_i;
      s1_zero  <= (power_i == '0);
      s1_log2  <= log2_q;
      s2_ch    <= s1_ch;
      s2_zero  <= s1_zero;
      s2_db    <= prod[P_W:16];
      ch_o     <= s2_ch;
      if (s2_zero) begin
        dB_o   <= DB_MIN;
        zero_o <= 1'b1;
        sat_o  <= 1'b0;
      end else if (r > R_MAX) begin
        dB_o   <= DB_MAX;
        zero_o <= 1'b0;
        sat_o  <= 1'b1;
      end else if (r < R_MIN) begin
        dB_o   <= DB_MIN;
        zero_o <= 1'b0;
        sat_o  <= 1'b1;
      end else begin
        dB_o   <= r[DB_W-1:0];
        zero_o <= 1'b0;
        sat_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) offset[c] <= '0;
    end else if (cfg_we && cfg_ok) begin
      offset[cfg_ch] <= cfg_offset;
    end
  end

`ifdef POWER_TO_DB_PEAK_HOLD_EN
  logic signed [DB_W-1:0] peak [NUM_CH];
  logic peak_ok, out_ok, out_hs;

  assign peak_ok = {1'b0, peak_ch_i} < (CH_W+1)'(NUM_CH);
  assign out_ok  = {1'b0, ch_o} < (CH_W+1)'(NUM_CH);
  assign out_hs  = valid_o && ready_i && out_ok;

  // Update is written after the clear so a same-channel collision loads dB_o
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) peak[c] <= DB_MIN;
      peak_o <= DB_MIN;
    end else begin
      peak_o <= peak_ok ? peak[peak_ch_i] : DB_MIN;
      if (peak_clr_i && peak_ok) peak[peak_ch_i] <= DB_MIN;
      if (out_hs && ((dB_o > peak[ch_o]) || (peak_clr_i && peak_ok && peak_ch_i == ch_o)))
        peak[ch_o] <= dB_o;
    end
  end
`endif

endmodule
